// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and data memory.
// The master (LSU) drives the request; the slave (memory) answers with ack and read data.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: byte enables, lane-replicated store data, req/ack handshake
// with wait-state timeout, and sign/zero-extended load data returned to writeback.
module load_store_unit #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_is_store,
    input  logic [2:0]          i_funct3,
    input  logic [XLEN-1:0]     i_alu_result,
    input  logic [XLEN-1:0]     i_store_data,
    output logic                o_busy,
    output logic                o_done,
    output logic [XLEN-1:0]     o_load_data,
    output logic                o_misaligned,
    output logic                o_timeout,
    load_store_unit_if.master   mem
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERR,
        S_REQ,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_store_data;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [XLEN-1:0]   r_load_data;

    logic              w_bad;
    logic              w_timeout_hit;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rshift;
    logic [XLEN-1:0]   w_load_ext;

    // Unknown funct3 values are folded into the misaligned error path.
    function automatic logic f_bad(input logic is_store, input logic [2:0] funct3,
                                   input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr_lo[0];
            3'b010:  bad = |addr_lo;
            3'b100:  bad = is_store;
            3'b101:  bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign w_bad = f_bad(i_is_store, i_funct3, i_alu_result[1:0]);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_is_store   <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
            r_wait_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_timeout_hit;
            if (r_state == S_IDLE && i_start) begin
                r_is_store   <= i_is_store;
                r_funct3     <= i_funct3;
                r_addr       <= i_alu_result;
                r_store_data <= i_store_data;
            end
            if (r_state != S_REQ) begin
                r_wait_cnt <= '0;
            end else if (!mem.mem_ack) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_state == S_REQ && mem.mem_ack && !r_is_store) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_next = w_bad ? S_ERR : S_REQ;
            S_ERR:  w_next = S_IDLE;
            S_REQ: begin
                if (mem.mem_ack) begin
                    w_next = S_RESP;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next        = S_RESP;
                    w_timeout_hit = 1'b1;
                end
            end
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_store_data;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Halfword accesses are 2-aligned, so a byte-granular shift also selects the right half.
    always_comb begin
        w_rshift = mem.mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_rshift[7:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
            default: w_load_ext = w_rshift;
        endcase
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_ERR) || (r_state == S_RESP);
    assign o_misaligned  = (r_state == S_ERR);
    assign o_timeout     = (r_state == S_RESP) && r_timeout;
    assign o_load_data   = r_load_data;

    assign mem.mem_req   = (r_state == S_REQ);
    assign mem.mem_we    = (r_state == S_REQ) && r_is_store;
    assign mem.mem_addr  = (r_state == S_REQ) ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign mem.mem_be    = (r_state == S_REQ) ? w_be : 4'b0000;
    assign mem.mem_wdata = (r_state == S_REQ && r_is_store) ? w_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// compared against an arithmetic reference model of sizes, lanes and extension.
module tb_load_store_unit;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 16;

    logic              clk;
    logic              i_reset;
    logic              i_start;
    logic              i_is_store;
    logic [2:0]        i_funct3;
    logic [XLEN-1:0]   i_alu_result;
    logic [XLEN-1:0]   i_store_data;
    logic              o_busy;
    logic              o_done;
    logic [XLEN-1:0]   o_load_data;
    logic              o_misaligned;
    logic              o_timeout;

    load_store_unit_if #(.XLEN(XLEN)) bus ();

    load_store_unit #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_load_data  (o_load_data),
        .o_misaligned (o_misaligned),
        .o_timeout    (o_timeout),
        .mem          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_load = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int     size;
        int     off;
        longint v;
        size = 1 << f3[1:0];
        off  = int'(addr % 4);
        v    = longint'(word >> (8 * off));
        if (size == 4) return v[31:0];
        v = v & ((64'd1 << (8 * size)) - 1);
        if (!f3[2] && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, input int ack_dly,
                             input logic [31:0] rdata, input bit junk);
        bit          bad;
        bit          timed_out;
        int          size;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] ebe_w;
        check("idle_busy", {31'b0, o_busy}, 32'd0);
        check("idle_done", {31'b0, o_done}, 32'd0);
        i_start      = 1'b1;
        i_is_store   = st;
        i_funct3     = f3;
        i_alu_result = addr;
        i_store_data = sd;
        @(negedge clk);
        i_start = junk;
        if (junk) begin
            i_is_store   = 1'($urandom);
            i_funct3     = 3'($urandom);
            i_alu_result = $urandom;
            i_store_data = $urandom;
        end
        size = 1 << f3[1:0];
        bad  = !legal(st, f3) || (addr % size != 0);
        if (bad) begin
            check("err_done", {31'b0, o_done}, 32'd1);
            check("err_misaligned", {31'b0, o_misaligned}, 32'd1);
            check("err_timeout", {31'b0, o_timeout}, 32'd0);
            check("err_req", {31'b0, bus.mem_req}, 32'd0);
            check("err_busy", {31'b0, o_busy}, 32'd1);
            check("err_load_data", o_load_data, m_load);
            i_start = 1'b0;
            @(negedge clk);
            check("post_err_busy", {31'b0, o_busy}, 32'd0);
            check("post_err_done", {31'b0, o_done}, 32'd0);
            check("post_err_req", {31'b0, bus.mem_req}, 32'd0);
            return;
        end
        ebe_w = ((32'd1 << size) - 1) << (addr % 4);
        ebe   = ebe_w[3:0];
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = sd[8*(i % size) +: 8];
        timed_out = 1'b1;
        for (int k = 0; k < MAX_WAIT; k++) begin
            check("req", {31'b0, bus.mem_req}, 32'd1);
            check("req_we", {31'b0, bus.mem_we}, {31'b0, st});
            check("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
            check("req_be", {28'b0, bus.mem_be}, {28'b0, ebe});
            if (st) check("req_wdata", bus.mem_wdata, ewd);
            check("req_done", {31'b0, o_done}, 32'd0);
            check("req_busy", {31'b0, o_busy}, 32'd1);
            if (k == ack_dly) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
                timed_out     = 1'b0;
            end else begin
                bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            if (!timed_out) break;
        end
        i_start       = 1'b0;
        bus.mem_ack   = timed_out;
        bus.mem_rdata = $urandom;
        if (!st && !timed_out) m_load = exp_load(f3, addr, rdata);
        check("resp_done", {31'b0, o_done}, 32'd1);
        check("resp_timeout", {31'b0, o_timeout}, {31'b0, timed_out});
        check("resp_misaligned", {31'b0, o_misaligned}, 32'd0);
        check("resp_req", {31'b0, bus.mem_req}, 32'd0);
        check("resp_busy", {31'b0, o_busy}, 32'd1);
        check("resp_load_data", o_load_data, m_load);
        @(negedge clk);
        check("post_busy", {31'b0, o_busy}, 32'd0);
        check("post_done", {31'b0, o_done}, 32'd0);
        check("post_req", {31'b0, bus.mem_req}, 32'd0);
        check("post_load_data", o_load_data, m_load);
        bus.mem_ack = 1'b0;
    endtask

    task automatic reset_mid_access();
        i_start      = 1'b1;
        i_is_store   = 1'b0;
        i_funct3     = 3'b010;
        i_alu_result = 32'h200;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_req", {31'b0, bus.mem_req}, 32'd1);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        m_load  = '0;
        check("rst_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_load_data", o_load_data, m_load);
        @(negedge clk);
        check("post_rst_done", {31'b0, o_done}, 32'd0);
        check("post_rst_busy", {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        i_reset       = 1'b1;
        i_start       = 1'b0;
        i_is_store    = 1'b0;
        i_funct3      = '0;
        i_alu_result  = '0;
        i_store_data  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        check("reset_busy", {31'b0, o_busy}, 32'd0);
        check("reset_done", {31'b0, o_done}, 32'd0);
        check("reset_misaligned", {31'b0, o_misaligned}, 32'd0);
        check("reset_timeout", {31'b0, o_timeout}, 32'd0);
        check("reset_load_data", o_load_data, 32'd0);
        check("reset_req", {31'b0, bus.mem_req}, 32'd0);

        do_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        check("lw_value", o_load_data, 32'hDEADBEEF);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456, 1'b0);
        check("lb_value", o_load_data, 32'hFFFFFF80);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80123456, 1'b0);
        check("lbu_value", o_load_data, 32'h00000080);
        do_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'h0, 1'b0);
        do_access(1'b1, 3'b000, 32'h101, 32'h00000012, 1, 32'h0, 1'b0);
        do_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1'b0);
        check("misaligned_keeps_load", o_load_data, 32'h00000080);
        do_access(1'b0, 3'b101, 32'h206, 32'h0, 3, 32'h8001_7FFF, 1'b0);
        do_access(1'b0, 3'b010, 32'h300, 32'h0, -1, 32'h0, 1'b0);
        do_access(1'b0, 3'b001, 32'h402, 32'h0, 2, 32'hBEEF_1234, 1'b1);
        reset_mid_access();

        for (int n = 0; n < 150; n++) begin
            logic        st;
            logic [2:0]  f3;
            int          dly;
            st  = 1'($urandom);
            f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2) | (st ? 0 : ($urandom_range(0, 1) << 2)));
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            do_access(st, f3, $urandom, $urandom, dly, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
